// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch : instruction-fetch stage between the PC stage and decode.
//   Issues in-order reads to instruction memory for the current PC. The sum of
//   outstanding reads, buffered instructions and responses still to be dropped
//   may not exceed DEPTH. Returned words are buffered with their PCs in a FIFO
//   that presents a valid/ready stream to decode. A redirect flushes the FIFO
//   and marks every in-flight response for discard.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   pc_data          current PC from the PC stage
//   redirect         PC rewritten this cycle (jump/branch); flush
//   pc_adv           request accepted; PC stage advances to pc_data+4
//   misaligned       pc_data[1:0] != 0 outside a redirect cycle; fetch stalls
//   imem_req_*       read request channel (valid/ready/addr)
//   imem_rsp_*       read response channel, in request order (valid/data)
//   inst_valid/ready head-of-buffer handshake towards decode
//   inst, inst_pc    head instruction and its PC
// ---------------------------------------------------------------------------
module if_fetch #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [XLEN-1:0] pc_data,
   input  logic            redirect,
   output logic            pc_adv,
   output logic            misaligned,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = CW + 2;

   // Held low through reset so no request is issued before the first live edge
   logic            r_active;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_drop;
   logic [CW-1:0]   r_fcnt;
   logic [AW-1:0]   r_pq_wptr;
   logic [AW-1:0]   r_pq_rptr;
   logic [AW-1:0]   r_f_wptr;
   logic [AW-1:0]   r_f_rptr;
   logic [XLEN-1:0] r_pq     [DEPTH];
   logic [XLEN-1:0] r_f_inst [DEPTH];
   logic [XLEN-1:0] r_f_pc   [DEPTH];

   logic [SW-1:0]   w_used;
   logic            w_credit;
   logic            w_aligned;
   logic            w_rsp_keep;
   logic            w_rsp_drop;
   logic            w_push;
   logic            w_pop;

   // Credit and request issue
   assign w_used         = SW'(r_outstanding) + SW'(r_fcnt) + SW'(r_drop);
   assign w_credit       = (w_used < SW'(DEPTH));
   assign w_aligned      = (pc_data[1:0] == 2'b00);
   assign misaligned     = r_active & ~redirect & ~w_aligned;
   assign imem_req_valid = r_active & ~redirect & w_aligned & w_credit;
   assign pc_adv         = imem_req_valid & imem_req_ready;
   assign imem_req_addr  = pc_data;

   // A response is consumed by the drop counter first; a kept response in the
   // redirect cycle still retires its outstanding slot but is not buffered.
   assign w_rsp_drop = imem_rsp_valid & (r_drop != '0);
   assign w_rsp_keep = imem_rsp_valid & (r_drop == '0);
   assign w_push     = w_rsp_keep & ~redirect;
   assign w_pop      = inst_valid & inst_ready;

   assign inst_valid = (r_fcnt != '0);
   assign inst       = r_f_inst[r_f_rptr];
   assign inst_pc    = r_f_pc[r_f_rptr];

   // Counters and pointers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_active      <= 1'b0;
         r_outstanding <= '0;
         r_drop        <= '0;
         r_fcnt        <= '0;
         r_pq_wptr     <= '0;
         r_pq_rptr     <= '0;
         r_f_wptr      <= '0;
         r_f_rptr      <= '0;
      end else begin
         r_active <= 1'b1;
         if (redirect) begin
            // Everything still in flight becomes a response to discard
            r_drop        <= r_drop - CW'(w_rsp_drop) + r_outstanding - CW'(w_rsp_keep);
            r_outstanding <= '0;
            r_fcnt        <= '0;
            r_pq_wptr     <= '0;
            r_pq_rptr     <= '0;
            r_f_wptr      <= '0;
            r_f_rptr      <= '0;
         end else begin
            r_outstanding <= r_outstanding + CW'(pc_adv) - CW'(w_rsp_keep);
            r_drop        <= r_drop - CW'(w_rsp_drop);
            r_fcnt        <= r_fcnt + CW'(w_push) - CW'(w_pop);
            if (pc_adv)     r_pq_wptr <= r_pq_wptr + AW'(1);
            if (w_rsp_keep) r_pq_rptr <= r_pq_rptr + AW'(1);
            if (w_push)     r_f_wptr  <= r_f_wptr + AW'(1);
            if (w_pop)      r_f_rptr  <= r_f_rptr + AW'(1);
         end
      end
   end

   // In-flight PC queue and instruction buffer storage
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_pq[i]     <= '0;
            r_f_inst[i] <= '0;
            r_f_pc[i]   <= '0;
         end
      end else begin
         if (pc_adv) r_pq[r_pq_wptr] <= pc_data;
         if (w_push) begin
            r_f_inst[r_f_wptr] <= imem_rsp_data;
            r_f_pc[r_f_wptr]   <= r_pq[r_pq_rptr];
         end
      end
   end

   // Buffer must never overflow; memory must never answer an unissued read
   a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
      !(w_push && !w_pop && (r_fcnt == CW'(DEPTH))));
   a_rsp_expected : assert property (@(posedge clk) disable iff (!rstn)
      !(imem_rsp_valid && (r_outstanding == '0) && (r_drop == '0)));

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC value, issues in-order read requests to instruction memory and tells the PC stage when it may advance.
- Buffers returned instructions with their PCs in a small FIFO that presents a valid/ready stream to decode.
- On a jump/branch redirect, flushes buffered entries and discards all in-flight responses.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 4, instruction buffer entries; also the credit limit on (outstanding requests + buffered entries); power of two, >= 2.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- pc_data  input  XLEN  current PC from the program counter stage
- redirect  input  1  PC is being rewritten this cycle (jump/branch taken); flush
- pc_adv  output  1  request accepted this cycle; PC stage advances to pc_data+4
- misaligned  output  1  pc_data[1:0] != 0 while not redirecting; no request issued
- imem_req_valid  output  1  read request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  read address (equals pc_data)
- imem_rsp_valid  input  1  read data valid; responses return in request order
- imem_rsp_data  input  XLEN  read data
- inst_valid  output  1  buffer head valid
- inst_ready  input  1  decode accepts head
- inst  output  XLEN  head instruction
- inst_pc  output  XLEN  PC of head instruction

Behaviour:
- Reset (async assert, sync deassert use): the following are 0 immediately on rstn low and stay 0 until the first clk edge after rstn rises.
  - Counters and flags: outstanding count, drop count, FIFO count, read/write pointers.
  - Outputs: inst_valid, imem_req_valid, pc_adv, misaligned; inst/inst_pc read as 0.
- Credit: credits_used = outstanding + fifo_count + drop_count. Credits are available when credits_used < DEPTH.
- Request issue (combinational):
  - imem_req_valid = !redirect & !misaligned & credits available.
  - imem_req_addr = pc_data.
  - pc_adv = imem_req_valid & imem_req_ready.
  - Memory side tolerates imem_req_valid deasserting without acceptance.
- In-flight tracking: a DEPTH-entry PC queue records imem_req_addr on each accept. Outstanding count +1 on accept, -1 on a kept response; both in the same cycle leaves it unchanged.
- Response capture:
  - When imem_rsp_valid and drop_count == 0: write {pc_queue head, imem_rsp_data} to the FIFO, pop the pc queue, decrement outstanding.
  - A response arriving in cycle N is visible at inst_valid in cycle N+1. There is no comb path from rsp to inst.
- Drain: the FIFO pops when inst_valid & inst_ready. Push and pop in the same cycle keep the count unchanged. The credit rule guarantees no overflow; an overflow is an assertion failure.
- Redirect, in the cycle redirect=1:
  - No request issued.
  - FIFO emptied at the next edge, so inst_valid=0 the next cycle.
  - pc queue cleared.
  - drop_count <= outstanding (minus 1 if a response arrives this same cycle); outstanding <= 0.
- Drop: while drop_count > 0, each imem_rsp_valid is discarded and decrements drop_count. A redirect during an active drop adds the remaining outstanding to drop_count.
- Misaligned: combinational and excludes the redirect cycle. The stage stalls until redirect; buffered entries still drain.
- Response with zero outstanding and zero drop is an assertion failure.
- Wrap-around: all pointers are log2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset: rstn low mid-traffic with 3 outstanding -> all counts 0, inst_valid=0, imem_req_valid=0 immediately.
- Streaming, always-ready memory with 1-cycle response, inst_ready=1, pc_data 0x0,0x4,0x8... -> one pc_adv per cycle; inst_pc 0x0 appears 2 cycles after first accept, then consecutive PCs every cycle.
- Backpressure: inst_ready=0 -> after DEPTH=4 accepts imem_req_valid=0 with FIFO holding PCs 0x0..0xC; inst_ready=1 for one cycle -> exactly one new request issued.
- Redirect with 2 outstanding and 2 buffered: redirect=1, pc_data=0x100 next cycle -> inst_valid=0 next cycle; next 2 responses dropped; first delivered inst_pc = 0x100.
- Redirect coincident with a response (1 outstanding) -> drop_count=0, response discarded, new request at 0x100 issued the cycle after redirect.
- Misaligned: pc_data=0x102 -> misaligned=1, imem_req_valid=0, pc_adv=0; redirect to 0x104 -> misaligned=0 and fetch resumes.
